// File: rtl/ov2640_config_sequencer.sv
// OV2640 power-up and register-table sequencer.
// Walks a command table and hands writes to an SCCB master.
module ov2640_config_sequencer #(
    parameter int CLKS_PER_MS = 50000,
    parameter int PWRUP_MS    = 2,
    parameter int BOOT_MS     = 5,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          resend,
    output logic [AW-1:0] cmd_addr,
    input  logic [15:0]   cmd_data,
    output logic          sccb_send,
    output logic [7:0]    sccb_rega,
    output logic [7:0]    sccb_value,
    input  logic          sccb_taken,
    output logic          config_finished,
    output logic          cam_reset,
    output logic          cam_pwdn
);

    localparam int PW_CYC = PWRUP_MS * CLKS_PER_MS;
    localparam int BT_CYC = BOOT_MS * CLKS_PER_MS;
    localparam int DL_MAX = 255 * CLKS_PER_MS;
    localparam int MAX_AB = (PW_CYC > BT_CYC) ? PW_CYC : BT_CYC;
    localparam int MAXC   = (MAX_AB > DL_MAX) ? MAX_AB : DL_MAX;
    localparam int CW     = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        PWRUP, BOOT, FETCH, WAIT_ROM, DECODE, SEND, DELAY, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;
    logic          is_end;
    logic          is_dly;
    logic          adv;
    logic          to_done;
    logic          restart;

    // Decide whether this cycle advances, finishes or restarts the table.
    always_comb begin
        is_end  = (cmd_data == 16'hFFFF);
        is_dly  = (cmd_data[15:8] == 8'hFE);
        adv     = 1'b0;
        to_done = 1'b0;
        restart = 1'b0;
        if (state == SEND && sccb_taken)
            adv = 1'b1;
        if (state == DELAY && cnt == CW'(1))
            adv = 1'b1;
        if (state == DECODE && is_dly && cmd_data[7:0] == 8'h00)
            adv = 1'b1;
        if (state == DECODE && is_end)
            to_done = 1'b1;
        if (adv && cmd_addr == '1)
            to_done = 1'b1;
        if (to_done && (pending || resend))
            restart = 1'b1;
        if (state == DONE && resend)
            restart = 1'b1;
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= PWRUP;
            cnt             <= '0;
            cmd_addr        <= '0;
            sccb_send       <= 1'b0;
            sccb_rega       <= 8'h00;
            sccb_value      <= 8'h00;
            config_finished <= 1'b0;
            cam_pwdn        <= 1'b1;
            cam_reset       <= 1'b0;
            pending         <= 1'b0;
        end else begin
            if (restart)
                pending <= 1'b0;
            else if (resend && state != DONE)
                pending <= 1'b1;

            if (restart) begin
                state           <= FETCH;
                cmd_addr        <= '0;
                cnt             <= '0;
                sccb_send       <= 1'b0;
                config_finished <= 1'b0;
            end else if (to_done) begin
                state           <= DONE;
                cnt             <= '0;
                sccb_send       <= 1'b0;
                config_finished <= 1'b1;
            end else if (adv) begin
                state     <= FETCH;
                cnt       <= '0;
                sccb_send <= 1'b0;
                cmd_addr  <= cmd_addr + 1'b1;
            end else begin
                case (state)
                    PWRUP: begin
                        if (cnt == CW'(PW_CYC - 1)) begin
                            cnt       <= '0;
                            cam_pwdn  <= 1'b0;
                            cam_reset <= 1'b1;
                            state     <= BOOT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BOOT: begin
                        if (cnt == CW'(BT_CYC - 1)) begin
                            cnt      <= '0;
                            cmd_addr <= '0;
                            state    <= FETCH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    FETCH:    state <= WAIT_ROM;
                    WAIT_ROM: state <= DECODE;
                    DECODE: begin
                        if (is_dly) begin
                            cnt   <= CW'(cmd_data[7:0]) * CW'(CLKS_PER_MS);
                            state <= DELAY;
                        end else begin
                            sccb_rega  <= cmd_data[15:8];
                            sccb_value <= cmd_data[7:0];
                            sccb_send  <= 1'b1;
                            state      <= SEND;
                        end
                    end
                    DELAY:   cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov2640_config_sequencer.sv
// Bench for ov2640_config_sequencer with a registered table ROM
// and an SCCB responder that takes each write 4 cycles after send.
module tb_ov2640_config_sequencer;

    localparam int CPM = 10;
    localparam int AW  = 3;

    typedef struct {
        logic [7:0][15:0] tbl;
        logic [AW-1:0]    addr;
        int               first_send;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          resend = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_data;
    logic          sccb_send;
    logic [7:0]    sccb_rega;
    logic [7:0]    sccb_value;
    logic          sccb_taken = 1'b0;
    logic          config_finished;
    logic          cam_reset;
    logic          cam_pwdn;

    logic [15:0]   rom [8];
    logic [15:0]   expq [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            first_send = -1;
    int            nwrites = 0;
    bit            resp_en = 1'b0;

    ov2640_config_sequencer #(
        .CLKS_PER_MS(CPM), .PWRUP_MS(2), .BOOT_MS(5), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .resend(resend),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .sccb_send(sccb_send), .sccb_rega(sccb_rega),
        .sccb_value(sccb_value), .sccb_taken(sccb_taken),
        .config_finished(config_finished),
        .cam_reset(cam_reset), .cam_pwdn(cam_pwdn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cmd_data <= rom[cmd_addr];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // SCCB responder and write scoreboard.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (resp_en && rst_n && sccb_send) begin
                logic [15:0] w;
                logic [15:0] e;
                w = {sccb_rega, sccb_value};
                if (first_send < 0) first_send = cyc;
                nwrites++;
                if (expq.size() == 0) begin
                    check("unexpected_write", int'(w), -1);
                end else begin
                    e = expq.pop_front();
                    check("write_data", int'(w), int'(e));
                end
                repeat (3) @(posedge clk);
                #1;
                check("send_held", int'(sccb_send), 1);
                check("rega_stable", int'({sccb_rega, sccb_value}), int'(w));
                sccb_taken = 1'b1;
                @(posedge clk); #1;
                sccb_taken = 1'b0;
                check("send_fall", int'(sccb_send), 0);
            end
        end
    end

    function automatic logic [7:0][15:0] mk(
        input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
        mk = {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic load(input logic [7:0][15:0] t);
        for (int i = 0; i < 8; i++) begin
            rom[i] = t[i];
        end
        for (int i = 0; i < 8; i++) begin
            if (t[i] == 16'hFFFF) break;
            if (t[i][15:8] != 8'hFE) expq.push_back(t[i]);
        end
    endtask

    // Reset, then check the power sequence timing.
    task automatic do_reset(input string tag);
        int fall;
        rst_n = 1'b0;
        first_send = -1;
        nwrites = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_rst_pwdn"}, int'(cam_pwdn), 1);
        check({tag, "_rst_reset"}, int'(cam_reset), 0);
        check({tag, "_rst_fin"}, int'(config_finished), 0);
        check({tag, "_rst_send"}, int'(sccb_send), 0);
        check({tag, "_rst_addr"}, int'(cmd_addr), 0);
        rst_n = 1'b1;
        fall = -1;
        for (int i = 0; i < 100 && fall < 0; i++) begin
            @(posedge clk); #1;
            if (!cam_pwdn) fall = cyc;
        end
        check({tag, "_pwdn_fall_cyc"}, fall, 20);
        check({tag, "_reset_rel"}, int'(cam_reset), 1);
    endtask

    task automatic wait_fin(input string tag);
        int n;
        n = 0;
        while (!config_finished && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_finished"}, int'(config_finished), 1);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0].tbl = mk(16'h1280, 16'hFF01, 16'hFFFF, 16'h0,
                         16'h0, 16'h0, 16'h0, 16'h0);
        vecs[0].addr = 3'd2; vecs[0].first_send = 73;
        vecs[1].tbl = mk(16'hFE03, 16'h3C55, 16'hFFFF, 16'h0,
                         16'h0, 16'h0, 16'h0, 16'h0);
        vecs[1].addr = 3'd2; vecs[1].first_send = 106;
        vecs[2].tbl = mk(16'h0111, 16'h0222, 16'h0333, 16'h0444,
                         16'h0555, 16'h0666, 16'h0777, 16'hFF00);
        vecs[2].addr = 3'd7; vecs[2].first_send = 73;
        vecs[3].tbl = mk(16'hFE00, 16'h3C55, 16'hFFFF, 16'h0,
                         16'h0, 16'h0, 16'h0, 16'h0);
        vecs[3].addr = 3'd2; vecs[3].first_send = 76;
        vecs[4].tbl = mk(16'hFFFF, 16'h1234, 16'h0, 16'h0,
                         16'h0, 16'h0, 16'h0, 16'h0);
        vecs[4].addr = 3'd0; vecs[4].first_send = -1;

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            expq.delete();
            load(vecs[v].tbl);
            resp_en = 1'b1;
            do_reset(tag);
            wait_fin(tag);
            check({tag, "_addr"}, int'(cmd_addr), int'(vecs[v].addr));
            check({tag, "_first_send"}, first_send, vecs[v].first_send);
            check({tag, "_queue_left"}, expq.size(), 0);
            check({tag, "_send_done"}, int'(sccb_send), 0);
        end

        // resend while a write waits for taken: replay, finish once.
        expq.delete();
        load(mk(16'h1280, 16'h3344, 16'hFFFF, 16'h0,
                16'h0, 16'h0, 16'h0, 16'h0));
        load(mk(16'h1280, 16'h3344, 16'hFFFF, 16'h0,
                16'h0, 16'h0, 16'h0, 16'h0));
        do_reset("rs");
        for (int i = 0; i < 200 && !sccb_send; i++) begin
            @(posedge clk); #1;
        end
        check("rs_send_seen", int'(sccb_send), 1);
        resend = 1'b1;
        @(posedge clk); #1;
        resend = 1'b0;
        wait_fin("rs");
        check("rs_writes", nwrites, 4);
        check("rs_queue_left", expq.size(), 0);

        // resend while DONE replays the table without power cycling.
        nwrites = 0;
        load(mk(16'h1280, 16'h3344, 16'hFFFF, 16'h0,
                16'h0, 16'h0, 16'h0, 16'h0));
        resend = 1'b1;
        @(posedge clk); #1;
        resend = 1'b0;
        check("rd_fin_clear", int'(config_finished), 0);
        check("rd_pwdn", int'(cam_pwdn), 0);
        wait_fin("rd");
        check("rd_writes", nwrites, 2);

        // async reset during SEND, then the power sequence restarts.
        resp_en = 1'b0;
        expq.delete();
        load(mk(16'hABCD, 16'hFFFF, 16'h0, 16'h0,
                16'h0, 16'h0, 16'h0, 16'h0));
        expq.delete();
        do_reset("ar");
        for (int i = 0; i < 200 && !sccb_send; i++) begin
            @(posedge clk); #1;
        end
        check("ar_send_seen", int'(sccb_send), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_send_async", int'(sccb_send), 0);
        check("ar_pwdn_async", int'(cam_pwdn), 1);
        check("ar_reset_async", int'(cam_reset), 0);
        resp_en = 1'b1;
        expq.delete();
        load(vecs[0].tbl);
        do_reset("ar2");
        wait_fin("ar2");
        check("ar2_first_send", first_send, 73);
        check("ar2_addr", int'(cmd_addr), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
